// File: rtl/dense_weight_fetch.sv
`timescale 1ns/1ps
// Streams packed dense-layer weights from dense_weight_rom onto a valid/ready bus with row/layer tags.
// Optional stall counter port stall_cycles is built when DENSE_FETCH_PERF_EN is defined.
module dense_weight_fetch #(
    parameter  int DEPTH = 16384,
    parameter  int WIDTH = 32,
    parameter  int DIM_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [DIM_W-1:0] row_words,
    input  logic [DIM_W-1:0] num_rows,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    rom_addr,
    output logic             rom_read_enable,
    input  logic [WIDTH-1:0] rom_weight,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [WIDTH-1:0] w_data,
    output logic             w_last_row,
    output logic             w_last_layer
`ifdef DENSE_FETCH_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int KW = 2 * DIM_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last_row;
        logic             last_layer;
    } entry_t;

    state_t           state_q;
    logic [AW-1:0]    base_q;
    logic [DIM_W-1:0] row_words_q;
    logic [DIM_W-1:0] num_rows_q;
    logic [KW-1:0]    k_q;
    logic [DIM_W-1:0] c_q;
    logic [DIM_W-1:0] row_q;
    logic [AW-1:0]    addr_q;
    logic             busy_q;
    logic             done_q;

    logic             inflight_q;
    logic             tag_row_q;
    logic             tag_layer_q;

    entry_t           fifo_q [2];
    entry_t           fifo_d [2];
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic             pop;
    logic             push;
    logic [2:0]       credit;
    logic             issue;
    logic [AW-1:0]    issue_addr;
    logic             last_row_now;
    logic             last_layer_now;
    logic             drain_done;
    entry_t           push_entry;

    assign pop        = w_valid & w_ready;
    assign push       = inflight_q;
    assign credit     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Words already buffered or returning from the ROM reserve a FIFO slot, so reads stop before overflow.
    assign issue      = (state_q == S_FETCH) && (credit < 3'd2);
    assign issue_addr = base_q + k_q[AW-1:0];

    assign last_row_now   = (c_q == row_words_q - DIM_W'(1));
    assign last_layer_now = last_row_now && (row_q == num_rows_q - DIM_W'(1));

    // The last word of the layer leaves the FIFO this cycle and nothing is still returning from the ROM.
    assign drain_done = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));

    assign rom_read_enable = issue;
    assign rom_addr        = issue ? issue_addr : addr_q;

    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            row_words_q <= '0;
            num_rows_q  <= '0;
            k_q         <= '0;
            c_q         <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        row_words_q <= row_words;
                        num_rows_q  <= num_rows;
                        k_q         <= '0;
                        c_q         <= '0;
                        row_q       <= '0;
                        busy_q      <= 1'b1;
                        if ((row_words == '0) || (num_rows == '0)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        k_q    <= k_q + KW'(1);
                        addr_q <= issue_addr;
                        if (last_row_now) begin
                            c_q   <= '0;
                            row_q <= row_q + DIM_W'(1);
                        end else begin
                            c_q <= c_q + DIM_W'(1);
                        end
                        if (last_layer_now) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tags ride alongside the ROM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            tag_row_q   <= 1'b0;
            tag_layer_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                tag_row_q   <= last_row_now;
                tag_layer_q <= last_layer_now;
            end
        end
    end

    assign push_entry = '{data: rom_weight, last_row: tag_row_q, last_layer: tag_layer_q};

    // NOTE: every variable gets a default with a blocking assignment first, so no path can infer a latch.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                fifo_d[count_q[0]] = push_entry;
                count_d            = count_q + 2'd1;
            end
            2'b01: begin
                fifo_d[0] = fifo_q[1];
                count_d   = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    fifo_d[0] = push_entry;
                end else begin
                    fifo_d[0] = fifo_q[1];
                    fifo_d[1] = push_entry;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the two FIFO slots are reset because the head drives w_data, which must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            fifo_q  <= fifo_d;
        end
    end

    assign w_valid      = (count_q != 2'd0);
    assign w_data       = fifo_q[0].data;
    assign w_last_row   = fifo_q[0].last_row;
    assign w_last_layer = fifo_q[0].last_layer;

`ifdef DENSE_FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_q <= '0;
        end else if (w_valid && !w_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_dense_weight_fetch.sv
`timescale 1ns/1ps
// Randomized self-checking bench for dense_weight_fetch against a word-list reference model.
module tb_dense_weight_fetch;

    localparam int DEPTH = 16384;
    localparam int WIDTH = 32;
    localparam int DIM_W = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [DIM_W-1:0] row_words;
    logic [DIM_W-1:0] num_rows;
    logic             busy;
    logic             done;
    logic [AW-1:0]    rom_addr;
    logic             rom_read_enable;
    logic [WIDTH-1:0] rom_weight = '0;
    logic             w_valid;
    logic             w_ready;
    logic [WIDTH-1:0] w_data;
    logic             w_last_row;
    logic             w_last_layer;
`ifdef DENSE_FETCH_PERF_EN
    logic [31:0]      stall_cycles;
`endif

    dense_weight_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .row_words       (row_words),
        .num_rows        (num_rows),
        .busy            (busy),
        .done            (done),
        .rom_addr        (rom_addr),
        .rom_read_enable (rom_read_enable),
        .rom_weight      (rom_weight),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_data          (w_data),
        .w_last_row      (w_last_row),
        .w_last_layer    (w_last_layer)
`ifdef DENSE_FETCH_PERF_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input int a);
        logic [31:0] x;
        x = 32'(a % DEPTH);
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ROM model: one-cycle read latency
    always @(posedge clk) begin
        if (rom_read_enable) rom_weight <= rom_word(int'(rom_addr));
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit           mon_en = 1'b0;
    logic [33:0]  obs_q [$];
    int           obs_cyc [$];
    int           iss_addr [$];
    int           iss_cyc [$];
    int           stall_cnt;
    int           valid_cnt;
    int           done_cnt;
    int           done_cyc;
    bit           prev_stall = 1'b0;
    logic [33:0]  prev_word;
    bit           prev_done = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rom_read_enable) begin
                iss_addr.push_back(int'(rom_addr));
                iss_cyc.push_back(cyc);
            end
            if (w_valid) valid_cnt++;
            if (w_valid && w_ready) begin
                obs_q.push_back({w_last_layer, w_last_row, w_data});
                obs_cyc.push_back(cyc);
            end
            if (prev_stall)
                check("hold_stable", {w_valid, w_last_layer, w_last_row, w_data}, {1'b1, prev_word});
            prev_stall = w_valid && !w_ready;
            prev_word  = {w_last_layer, w_last_row, w_data};
            if (w_valid && !w_ready) stall_cnt++;
            if (prev_done) check("busy_after_done", busy, 1'b0);
            prev_done = done;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", busy, 1'b1);
            end
        end else begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end
    end

    function automatic logic ready_for(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return (t % 4 == 0) || (t % 4 == 3);
            default: return 1'($urandom_range(1, 0));
        endcase
    endfunction

    task automatic run_layer(input int base, input int rw, input int nr, input int mode,
                             input bit extra_start);
        logic [33:0] expq [$];
        int n;
        int s;
        n = rw * nr;
        for (int i = 0; i < n; i++)
            expq.push_back({(i == n - 1), ((i % rw) == rw - 1), rom_word(base + i)});

        @(posedge clk);
        #1;
        obs_q.delete(); obs_cyc.delete(); iss_addr.delete(); iss_cyc.delete();
        stall_cnt = 0; valid_cnt = 0; done_cnt = 0; done_cyc = -1;
        mon_en    = 1'b1;
        start     = 1'b1;
        base_addr = AW'(base);
        row_words = DIM_W'(rw);
        num_rows  = DIM_W'(nr);
        w_ready   = ready_for(mode, 0);
        s = cyc;

        for (int t = 1; t < 2000 && done_cnt == 0; t++) begin
            @(posedge clk);
            #1;
            start   = extra_start && (t == 2);
            w_ready = ready_for(mode, t);
            if (start) begin
                base_addr = AW'(base + 1000);
                row_words = 16'd1;
                num_rows  = 16'd1;
            end
        end
        w_ready = 1'b1;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("done_count", done_cnt, 1);
        check("word_count", obs_q.size(), n);
        check("issue_count", iss_addr.size(), n);
        if (obs_q.size() == n) begin
            for (int i = 0; i < n; i++) check("word", obs_q[i], expq[i]);
        end
        if (iss_addr.size() == n) begin
            for (int i = 0; i < n; i++) check("rom_addr", iss_addr[i], (base + i) % DEPTH);
        end
        if (n == 0) begin
            check("zero_no_valid", valid_cnt, 0);
            check("zero_done_lat", (done_cyc - s >= 1) && (done_cyc - s <= 2), 1'b1);
        end else if (obs_q.size() == n) begin
            check("done_after_last", done_cyc, obs_cyc[n-1] + 1);
            if (mode == 0) begin
                check("first_valid_lat", obs_cyc[0] - s, 3);
                check("stream_contig", obs_cyc[n-1] - obs_cyc[0], n - 1);
                if (iss_cyc.size() == n) begin
                    check("first_issue", iss_cyc[0] - s, 1);
                    check("issue_contig", iss_cyc[n-1] - iss_cyc[0], n - 1);
                end
            end
        end
`ifdef DENSE_FETCH_PERF_EN
        check("stall_cycles", stall_cycles, stall_cnt);
`endif
        check("idle_busy", busy, 1'b0);
        mon_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; w_ready = 1'b0;
        base_addr = '0; row_words = '0; num_rows = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  busy, 1'b0);
        check("rst_done",  done, 1'b0);
        check("rst_valid", w_valid, 1'b0);
        check("rst_ren",   rom_read_enable, 1'b0);
        check("rst_addr",  rom_addr, 0);
        check("rst_data",  {w_last_layer, w_last_row, w_data}, 0);
`ifdef DENSE_FETCH_PERF_EN
        check("rst_stall", stall_cycles, 0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;

        run_layer(0, 4, 2, 0, 1'b0);
        run_layer(0, 4, 2, 1, 1'b0);
        run_layer(DEPTH - 2, 4, 1, 0, 1'b0);
        run_layer(7, 0, 5, 0, 1'b0);
        run_layer(100, 3, 2, 1, 1'b1);

        // Reset mid-layer with the FIFO full and a new read being issued
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 14'd50; row_words = 16'd4; num_rows = 16'd3; w_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 w_ready = 1'b1;
        @(negedge clk);
        check("pre_reset_valid", w_valid, 1'b1);
        check("pre_reset_ren", rom_read_enable, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", w_valid, 1'b0);
        check("mid_rst_busy",  busy, 1'b0);
        check("mid_rst_ren",   rom_read_enable, 1'b0);
        check("mid_rst_done",  done, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_layer(50, 4, 3, 0, 1'b0);

        for (int r = 0; r < 6; r++)
            run_layer(int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(5, 1)),
                      int'($urandom_range(4, 1)), 2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
